// File: rtl/fighter_action_fsm.sv
// Per-player action sequencer: tracks horizontal position and timed actions
// (jump/kick/punch/guard), emitting registered status and one-cycle event pulses.
module fighter_action_fsm #(
  parameter int unsigned POS_WIDTH    = 4,
  parameter int unsigned POS_MIN      = 0,
  parameter int unsigned POS_MAX      = 15,
  parameter int unsigned POS_INIT     = 0,
  parameter int unsigned JUMP_CYCLES  = 8,
  parameter int unsigned KICK_CYCLES  = 4,
  parameter int unsigned PUNCH_CYCLES = 3,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           action,
  output logic [POS_WIDTH-1:0] pos,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 hit,
  output logic                 done
);

  localparam int unsigned MAX_JK  = (JUMP_CYCLES > KICK_CYCLES) ? JUMP_CYCLES : KICK_CYCLES;
  localparam int unsigned MAX_PG  = (PUNCH_CYCLES > GUARD_CYCLES) ? PUNCH_CYCLES : GUARD_CYCLES;
  localparam int unsigned MAX_DUR = (MAX_JK > MAX_PG) ? MAX_JK : MAX_PG;
  // Counter only ever holds DUR-1, so clog2(MAX_DUR) bits suffice.
  localparam int unsigned CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [2:0] ACT_J  = 3'b001;
  localparam logic [2:0] ACT_K  = 3'b010;
  localparam logic [2:0] ACT_P  = 3'b011;
  localparam logic [2:0] ACT_W  = 3'b100;
  localparam logic [2:0] ACT_MF = 3'b101;
  localparam logic [2:0] ACT_MB = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_JUMP  = 3'b001,
    ST_KICK  = 3'b010,
    ST_PUNCH = 3'b011,
    ST_GUARD = 3'b100
  } state_t;

  state_t               cur_state, nxt_state;
  logic [CNT_W-1:0]     cnt, nxt_cnt;
  logic [POS_WIDTH-1:0] nxt_pos;
  logic                 nxt_hit, nxt_done;

  // State, position and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_IDLE;
      cnt       <= '0;
      pos       <= POS_WIDTH'(POS_INIT);
      busy      <= 1'b0;
      hit       <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= nxt_cnt;
      pos       <= nxt_pos;
      busy      <= (nxt_state != ST_IDLE);
      hit       <= nxt_hit;
      done      <= nxt_done;
    end
  end

  // Next-state, counter and position logic
  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cnt;
    nxt_pos   = pos;
    nxt_hit   = 1'b0;
    nxt_done  = 1'b0;

    // Movement is allowed on the ground and in the air, including the jump's final cycle
    if (cur_state == ST_IDLE || cur_state == ST_JUMP) begin
      if (action == ACT_MF && pos != POS_WIDTH'(POS_MAX)) begin
        nxt_pos = pos + POS_WIDTH'(1);
      end else if (action == ACT_MB && pos != POS_WIDTH'(POS_MIN)) begin
        nxt_pos = pos - POS_WIDTH'(1);
      end
    end

    case (cur_state)
      ST_IDLE: begin
        case (action)
          ACT_J: begin
            nxt_state = ST_JUMP;
            nxt_cnt   = CNT_W'(JUMP_CYCLES - 1);
          end
          ACT_K: begin
            nxt_state = ST_KICK;
            nxt_cnt   = CNT_W'(KICK_CYCLES - 1);
            nxt_hit   = 1'b1;
          end
          ACT_P: begin
            nxt_state = ST_PUNCH;
            nxt_cnt   = CNT_W'(PUNCH_CYCLES - 1);
            nxt_hit   = 1'b1;
          end
          ACT_W: begin
            nxt_state = ST_GUARD;
            nxt_cnt   = CNT_W'(GUARD_CYCLES - 1);
          end
          default: ;
        endcase
      end
      ST_JUMP, ST_KICK, ST_PUNCH, ST_GUARD: begin
        if (cnt == '0) begin
          nxt_state = ST_IDLE;
          nxt_done  = 1'b1;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed self-checking bench for fighter_action_fsm with default parameters.
module tb_fighter_action_fsm;

  logic       clk;
  logic       rst;
  logic [2:0] action;
  logic [3:0] pos;
  logic [2:0] state;
  logic       busy;
  logic       hit;
  logic       done;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] A_NONE = 3'b000;
  localparam logic [2:0] A_J    = 3'b001;
  localparam logic [2:0] A_K    = 3'b010;
  localparam logic [2:0] A_P    = 3'b011;
  localparam logic [2:0] A_W    = 3'b100;
  localparam logic [2:0] A_MF   = 3'b101;
  localparam logic [2:0] A_MB   = 3'b110;
  localparam logic [2:0] A_NOP  = 3'b111;

  fighter_action_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .action (action),
    .pos    (pos),
    .state  (state),
    .busy   (busy),
    .hit    (hit),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive an action, clock it in, and settle just after the edge
  task automatic tick(input logic [2:0] a);
    action = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int p, input int s, input int b,
                           input int h, input int d);
    check({tag, ".pos"},   int'(pos),   p);
    check({tag, ".state"}, int'(state), s);
    check({tag, ".busy"},  int'(busy),  b);
    check({tag, ".hit"},   int'(hit),   h);
    check({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    rst    = 1'b1;
    action = A_NONE;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Back-off saturation at POS_MIN
    for (int i = 0; i < 3; i++) begin
      tick(A_MB);
      check("mb_sat.pos", int'(pos), 0);
    end

    // Forward movement saturates at POS_MAX
    for (int i = 1; i <= 20; i++) begin
      tick(A_MF);
      check("mf_sat.pos", int'(pos), (i < 15) ? i : 15);
      check("mf_sat.state", int'(state), 0);
    end

    // Code 111 is a no-op
    for (int i = 0; i < 5; i++) begin
      tick(A_NOP);
      check_all("nop", 15, 0, 0, 0, 0);
    end

    // Kick timing: 4 busy cycles, hit on entry only, done on exit
    tick(A_K);
    check_all("kick_entry", 15, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(A_NONE);
      check_all("kick_mid", 15, 2, 1, 0, 0);
    end
    tick(A_NONE);
    check_all("kick_exit", 15, 0, 0, 0, 1);
    tick(A_NONE);
    check_all("kick_after", 15, 0, 0, 0, 0);

    // Walk back to position 5
    for (int i = 0; i < 10; i++) tick(A_MB);
    check("walk_back.pos", int'(pos), 5);

    // Jump with air control: mf on every jump cycle including the exit edge
    tick(A_J);
    check_all("jump_entry", 5, 1, 1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      tick(A_MF);
      check_all("jump_air", 5 + i, 1, 1, 0, 0);
    end
    tick(A_MF);
    check_all("jump_exit", 13, 0, 0, 0, 1);
    tick(A_NONE);
    check_all("jump_after", 13, 0, 0, 0, 0);

    // Punch ignores further actions, including on its exit edge
    tick(A_P);
    check_all("punch_entry", 13, 3, 1, 1, 0);
    tick(A_K);
    check_all("punch_k", 13, 3, 1, 0, 0);
    tick(A_W);
    check_all("punch_w", 13, 3, 1, 0, 0);
    tick(A_K);
    check_all("punch_exit_k", 13, 0, 0, 0, 1);
    tick(A_K);
    check_all("kick_after_punch", 13, 2, 1, 1, 0);

    // Asynchronous reset mid-kick takes effect before the next edge
    tick(A_NONE);
    check_all("kick_before_rst", 13, 2, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst", 0, 0, 0, 0, 0);

    // Holding k: 4 kick cycles, one idle cycle with done, then a fresh kick
    tick(A_K);
    check_all("hold_k1", 0, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(A_K);
      check_all("hold_k_mid", 0, 2, 1, 0, 0);
    end
    tick(A_K);
    check_all("hold_k_idle", 0, 0, 0, 0, 1);
    tick(A_K);
    check_all("hold_k2", 0, 2, 1, 1, 0);

    // Guard lasts 2 cycles
    for (int i = 0; i < 4; i++) tick(A_NONE);
    tick(A_W);
    check_all("guard_entry", 0, 4, 1, 0, 0);
    tick(A_NONE);
    check_all("guard_mid", 0, 4, 1, 0, 0);
    tick(A_NONE);
    check_all("guard_exit", 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
